blit_write_buffer: RTL



---
 rtl/blit_write_buffer.sv | 112 +++++++++++
 1 files changed

// File: rtl/blit_write_buffer.sv
// Write-combining buffer: merges blitter byte writes into one 32-byte line and drains it as an 8-beat masked SDRAM burst.
// Latency: hits/empty writes accepted same cycle; a miss stalls for 1 + ack wait + beats + 1 cycles. Optional BLIT_WBUF_AUTOFLUSH_EN drains a full line.
module blit_write_buffer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] write_address,
  input  logic        write_request,
  input  logic [7:0]  write_data,
  output logic        write_stall,
  input  logic        flush,
  output logic        idle,
  output logic [25:0] mem_address,
  output logic        mem_request,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic        mem_valid,
  input  logic        mem_complete
);

  typedef enum logic [1:0] {FILL, REQ, BURST} state_t;

  state_t      state;
  logic [31:0] data [8];
  logic [31:0] byte_en;
  logic [20:0] tag;
  logic        line_open;
  logic [2:0]  beat_ptr;

  logic        main;
  logic        hit;
  logic        miss;
  logic        drain;
  logic        accept;
  logic        full_go;
  logic [31:0] wr_bit;

  assign main   = (write_address[31:26] == 6'd0);
  assign hit    = line_open && (tag == write_address[25:5]);
  assign miss   = write_request && main && line_open && !hit;
  assign drain  = (state == FILL) && line_open && (miss || flush);
  assign wr_bit = 32'd1 << write_address[4:0];

  assign write_stall = !reset && write_request && main &&
                       ((state != FILL) || miss || (flush && line_open));
  assign accept      = !reset && (state == FILL) && write_request && main && !write_stall;

`ifdef BLIT_WBUF_AUTOFLUSH_EN
  // Only a merging write can complete the line; an empty-buffer write sets a single bit.
  assign full_go = accept && line_open && (&(byte_en | wr_bit));
`else
  assign full_go = 1'b0;
`endif

  assign idle        = reset || ((state == FILL) && !line_open);
  assign mem_address = {tag, 5'b00000};
  assign mem_write   = 1'b1;
  assign mem_wdata   = data[beat_ptr];
  assign mem_wstrb   = byte_en[{beat_ptr, 2'b00} +: 4];

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FILL;
      mem_request <= 1'b0;
      line_open   <= 1'b0;
      byte_en     <= 32'd0;
      tag         <= 21'd0;
      beat_ptr    <= 3'd0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            if (line_open) begin
              byte_en <= byte_en | wr_bit;
            end else begin
              byte_en   <= wr_bit;
              tag       <= write_address[25:5];
              line_open <= 1'b1;
            end
          end
          if (drain || full_go) begin
            state       <= REQ;
            mem_request <= 1'b1;
            beat_ptr    <= 3'd0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_request <= 1'b0;
            state       <= BURST;
          end
        end
        BURST: begin
          if (mem_valid) beat_ptr <= beat_ptr + 3'd1;
          if (mem_complete) begin
            byte_en   <= 32'd0;
            line_open <= 1'b0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Line contents are left unreset; byte_en alone decides what is valid.
  always_ff @(posedge clock) begin
    if (accept) data[write_address[4:2]][{write_address[1:0], 3'b000} +: 8] <= write_data;
  end

endmodule
